b3_count_ctrl: RTL and testbench

Sequencer for a chain of base-3 up-counter digits. It accepts a start command with a base-3 target, advances the digit chain by one count per clock, and supports pause and abort. It raises `done` when the count equals the target and holds it until acknowledged. It sits between a host/control FSM and the base-3 counting datapath, so the digit chain is never enabled directly by the host.

---
 rtl/b3_count_ctrl_pkg.sv | 23 ++
 rtl/b3_count_ctrl_if.sv | 24 ++
 rtl/b3_digit_reg.sv | 29 ++
 rtl/b3_count_ctrl.sv | 137 +++++++++++++
 tb/tb_b3_count_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/b3_count_ctrl_pkg.sv
// Shared definitions for the base-3 count sequencer: state encoding,
// digit codes and the per-digit width.
package b3_count_ctrl_pkg;

  localparam int DIGIT_W = 2;

  localparam logic [DIGIT_W-1:0] B3_D0  = 2'b00;
  localparam logic [DIGIT_W-1:0] B3_D1  = 2'b01;
  localparam logic [DIGIT_W-1:0] B3_D2  = 2'b10;
  localparam logic [DIGIT_W-1:0] B3_ILL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  function automatic logic digit_legal(input logic [DIGIT_W-1:0] d);
    return (d != B3_ILL);
  endfunction

endpackage

// File: rtl/b3_count_ctrl_if.sv
// Host-side command/status bundle of the base-3 count sequencer.
interface b3_count_ctrl_if #(
  parameter int DIGITS = 3
);
  logic                  start;
  logic [2*DIGITS-1:0]   target;
  logic                  pause;
  logic                  abort;
  logic                  ack;
  logic [2*DIGITS-1:0]   count;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, target, pause, abort, ack,
    input  count, busy, done, err
  );

  modport slave (
    input  start, target, pause, abort, ack,
    output count, busy, done, err
  );
endinterface

// File: rtl/b3_digit_reg.sv
// One base-3 digit (codes 00/01/10) with synchronous clear and a
// same-cycle carry so a chain of these ripples in one clock.
module b3_digit_reg
  import b3_count_ctrl_pkg::*;
(
  input  logic               clock,
  input  logic               clear,
  input  logic               enable,
  output logic               carry,
  output logic [DIGIT_W-1:0] value
);

  logic [DIGIT_W-1:0] value_r;

  // Digit state: clear wins, then wrap 2 -> 0 on enable, else hold.
  always_ff @(posedge clock) begin
    if (clear) begin
      value_r <= B3_D0;
    end else if (enable) begin
      value_r <= (value_r == B3_D2) ? B3_D0 : (value_r + 2'd1);
    end else begin
      value_r <= value_r;
    end
  end

  assign carry = enable && (value_r == B3_D2);
  assign value = value_r;

endmodule

// File: rtl/b3_count_ctrl.sv
// Sequencer that drives a chain of base-3 digits from start to target,
// with pause, abort and a done flag held until acknowledged.
module b3_count_ctrl
  import b3_count_ctrl_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic             clock,
  input  logic             reset,
  b3_count_ctrl_if.slave   bus
);

  localparam int CW = DIGIT_W * DIGITS;

  state_t          state_r;
  state_t          next_state_s;
  logic [CW-1:0]   target_r;
  logic [CW-1:0]   count_s;
  logic            busy_r;
  logic            done_r;
  logic            err_r;
  logic            err_next_s;
  logic            latch_s;
  logic            inc_s;
  logic            clr_s;
  logic            legal_s;
  logic [DIGITS:0] carry_s;
  logic            carry_unused_s;

  // Every digit of the requested target must be a legal base-3 code.
  always_comb begin
    legal_s = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!digit_legal(bus.target[DIGIT_W*i +: DIGIT_W])) begin
        legal_s = 1'b0;
      end else begin
        legal_s = legal_s;
      end
    end
  end

  // Next-state, increment and clear decode; RUN priority is abort, match, pause.
  always_comb begin
    next_state_s = state_r;
    err_next_s   = 1'b0;
    latch_s      = 1'b0;
    inc_s        = 1'b0;
    clr_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start && legal_s) begin
          latch_s      = 1'b1;
          next_state_s = ST_RUN;
        end else if (bus.start) begin
          err_next_s   = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          clr_s        = 1'b1;
          next_state_s = ST_IDLE;
        end else if (count_s == target_r) begin
          next_state_s = ST_DONE;
        end else if (bus.pause) begin
          next_state_s = ST_HOLD;
        end else begin
          inc_s        = 1'b1;
        end
      end
      ST_HOLD: begin
        if (bus.abort) begin
          clr_s        = 1'b1;
          next_state_s = ST_IDLE;
        end else if (!bus.pause) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_HOLD;
        end
      end
      ST_DONE: begin
        if (bus.ack) begin
          clr_s        = 1'b1;
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: begin
        clr_s        = 1'b1;
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State, latched target and status flags decoded from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      target_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      target_r <= latch_s ? bus.target : target_r;
      busy_r   <= (next_state_s == ST_RUN) || (next_state_s == ST_HOLD);
      done_r   <= (next_state_s == ST_DONE);
      err_r    <= err_next_s;
    end
  end

  assign carry_s[0] = inc_s;

  // The count never passes the target, so the top carry is never consumed.
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      b3_digit_reg u_digit (
        .clock  (clock),
        .clear  (reset || clr_s),
        .enable (carry_s[g]),
        .carry  (carry_s[g+1]),
        .value  (count_s[DIGIT_W*g +: DIGIT_W])
      );
    end
  endgenerate

  assign carry_unused_s = carry_s[DIGITS];

  assign bus.count = count_s;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.err   = err_r;

endmodule

// File: tb/tb_b3_count_ctrl.sv
// Directed bench for b3_count_ctrl: each input change is applied just after
// a rising edge and sampled by the DUT on the following edge.
module tb_b3_count_ctrl;

  logic clock;
  logic reset;
  int   n_assert;
  int   n_fail;

  b3_count_ctrl_if #(.DIGITS(3)) bus ();

  b3_count_ctrl #(.DIGITS(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] to_b3(input int v);
    logic [5:0] r;
    int         x;
    int         d;
    x = v;
    r = 6'd0;
    for (int i = 0; i < 3; i++) begin
      d = x % 3;
      r[2*i +: 2] = 2'(d);
      x = x / 3;
    end
    return r;
  endfunction

  task automatic check_status(input string tag, input logic [5:0] cnt,
                              input logic b, input logic d, input logic e);
    check({tag, ".count"}, 8'(bus.count), 8'(cnt));
    check({tag, ".busy"},  8'(bus.busy),  8'(b));
    check({tag, ".done"},  8'(bus.done),  8'(d));
    check({tag, ".err"},   8'(bus.err),   8'(e));
  endtask

  task automatic do_start(input logic [5:0] tgt);
    bus.start  = 1'b1;
    bus.target = tgt;
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
  endtask

  initial begin
    clock      = 1'b0;
    n_assert   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.target = 6'd0;
    bus.pause  = 1'b0;
    bus.abort  = 1'b0;
    bus.ack    = 1'b0;
    tick();
    tick();
    check_status("reset", 6'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    check_status("idle", 6'd0, 1'b0, 1'b0, 1'b0);

    // Target 0: one RUN cycle, then DONE with count 0.
    do_start(6'b00_00_00);
    check_status("t0.run", 6'd0, 1'b1, 1'b0, 1'b0);
    tick();
    check_status("t0.done", 6'd0, 1'b0, 1'b1, 1'b0);
    do_ack();
    check_status("t0.ack", 6'd0, 1'b0, 1'b0, 1'b0);

    // Target 23 = {10,01,10}: every step of the count, carry at 3.
    do_start(6'b10_01_10);
    check("t23.c0", 8'(bus.count), 8'(6'd0));
    for (int k = 1; k <= 23; k++) begin
      tick();
      check("t23.step", 8'(bus.count), 8'(to_b3(k)));
      check("t23.nodone", 8'(bus.done), 8'(1'b0));
      if (k == 3) begin
        check("t23.carry", 8'(bus.count), 8'(6'b00_01_00));
      end else begin
        check("t23.busy", 8'(bus.busy), 8'(1'b1));
      end
    end
    tick();
    check_status("t23.done", 6'b10_01_10, 1'b0, 1'b1, 1'b0);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check_status("t23.hold", 6'b10_01_10, 1'b0, 1'b1, 1'b0);
    do_ack();
    check_status("t23.ack", 6'd0, 1'b0, 1'b0, 1'b0);

    // Target 5 with pause high for 3 cycles once count reads 2.
    do_start(6'b00_01_10);
    tick();
    tick();
    check("t5.c2", 8'(bus.count), 8'(6'd2));
    bus.pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_status("t5.hold", 6'd2, 1'b1, 1'b0, 1'b0);
    end
    bus.pause = 1'b0;
    tick();
    check_status("t5.resume", 6'd2, 1'b1, 1'b0, 1'b0);
    tick();
    check("t5.c3", 8'(bus.count), 8'(6'b00_01_00));
    tick();
    tick();
    check_status("t5.c5", 6'b00_01_10, 1'b1, 1'b0, 1'b0);
    tick();
    check_status("t5.done", 6'b00_01_10, 1'b0, 1'b1, 1'b0);
    do_ack();

    // Illegal digit 1 = 11: err pulse, no run; then a legal start is taken.
    do_start(6'b00_11_00);
    check_status("ill.err", 6'd0, 1'b0, 1'b0, 1'b1);
    tick();
    check_status("ill.clear", 6'd0, 1'b0, 1'b0, 1'b0);
    do_start(6'b00_00_01);
    check_status("ill.next", 6'd0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    check_status("ill.done", 6'b00_00_01, 1'b0, 1'b1, 1'b0);
    do_ack();

    // Abort at count 7 toward target 20.
    do_start(6'b10_00_10);
    for (int k = 0; k < 7; k++) tick();
    check("ab.c7", 8'(bus.count), 8'(6'b00_10_01));
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_status("ab.idle", 6'd0, 1'b0, 1'b0, 1'b0);

    // Abort coinciding with count == target: abort wins.
    do_start(6'b00_00_10);
    tick();
    tick();
    check("abm.c2", 8'(bus.count), 8'(6'b00_00_10));
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_status("abm.idle", 6'd0, 1'b0, 1'b0, 1'b0);

    // Reset while in DONE.
    do_start(6'b00_00_01);
    tick();
    tick();
    check("rd.done", 8'(bus.done), 8'(1'b1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_status("rd.reset", 6'd0, 1'b0, 1'b0, 1'b0);

    // Full scale 26 = all digits 10, no wrap; ack with a simultaneous start.
    do_start(6'b10_10_10);
    for (int k = 1; k <= 26; k++) begin
      tick();
      check("fs.step", 8'(bus.count), 8'(to_b3(k)));
    end
    check("fs.max", 8'(bus.count), 8'(6'b10_10_10));
    tick();
    check_status("fs.done", 6'b10_10_10, 1'b0, 1'b1, 1'b0);
    tick();
    check_status("fs.nowrap", 6'b10_10_10, 1'b0, 1'b1, 1'b0);
    bus.ack    = 1'b1;
    bus.start  = 1'b1;
    bus.target = 6'b00_00_11 ^ 6'b00_00_01;
    tick();
    bus.ack    = 1'b0;
    bus.start  = 1'b0;
    check_status("fs.ack", 6'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check_status("fs.nostart", 6'd0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a run.
    do_start(6'b10_10_10);
    tick();
    tick();
    check("rr.c2", 8'(bus.count), 8'(6'd2));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_status("rr.reset", 6'd0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
